// File: rtl/timer_60s_pkg.sv
// Shared types and constants for the 0.0-59.9 s timer: speed table,
// seven-segment codes (active-low {g,f,e,d,c,b,a}) and digit limits.
package timer_60s_pkg;

   typedef enum logic [1:0] {
      SPD_X1  = 2'd0,
      SPD_X2  = 2'd1,
      SPD_X4  = 2'd2,
      SPD_X10 = 2'd3
   } speed_e;

   localparam int unsigned SPEED_MULT [4] = '{1, 2, 4, 10};

   localparam logic [3:0] MAX_TENS  = 4'd5;
   localparam logic [3:0] MAX_DIGIT = 4'd9;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Terminal count: 00.0 when counting down, 59.9 when counting up.
   function automatic logic at_limit(input logic down, input logic [3:0] t,
                                     input logic [3:0] u, input logic [3:0] f);
      if (down) return (t == 4'd0) && (u == 4'd0) && (f == 4'd0);
      return (t == MAX_TENS) && (u == MAX_DIGIT) && (f == MAX_DIGIT);
   endfunction

endpackage

// File: rtl/timer_60s_core_if.sv
// Board-side bundle for timer_60s_core: keys/switches in, display signals out.
interface timer_60s_core_if;
   logic       ret, en, pause;
   logic       key0, key1, key2, key4, key5, key6;
   logic [3:0] ten, one;
   logic [3:0] tens;
   logic [6:0] out_ge, out_xiao;
   logic       point, led;

   modport master (
      output ret, en, pause, key0, key1, key2, key4, key5, key6, ten, one,
      input  tens, out_ge, out_xiao, point, led
   );
   modport slave (
      input  ret, en, pause, key0, key1, key2, key4, key5, key6, ten, one,
      output tens, out_ge, out_xiao, point, led
   );
endinterface

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; codes above 9 blank the digit.
module seg7_decode
   import timer_60s_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/timer_60s_core.sv
// 0.0-59.9 s up/down timer with preset, pause, speed and display modes.
// Define KEY_SYNC_EN to put 2-flop synchronizers on ret, keys and pause.
module timer_60s_core
   import timer_60s_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input logic             clk_50M,
   input logic             rst,
   timer_60s_core_if.slave io
);
   localparam int unsigned CW = $clog2(CLK_HZ / 10);

   // {pause, key6, key5, key4, key2, key1, key0, ret}
   logic [7:0] raw_in, sync_in;
   assign raw_in = {io.pause, io.key6, io.key5, io.key4, io.key2, io.key1, io.key0, io.ret};

`ifdef KEY_SYNC_EN
   localparam logic [7:0] SYNC_RST = 8'h01; // ret idles high
   logic [7:0] s1_q, s1_d, s2_q, s2_d;
   always_comb begin
      s1_d = raw_in;
      s2_d = s1_q;
   end
   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         s1_q <= SYNC_RST;
         s2_q <= SYNC_RST;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end
   assign sync_in = s2_q;
`else
   assign sync_in = raw_in;
`endif

   logic       ret_n, key2;
   logic [5:0] edge_src, prev_q, prev_d, act; // {pause, key6, key5, key4, key1, key0}
   assign ret_n    = sync_in[0];
   assign key2     = sync_in[3];
   assign edge_src = {sync_in[7:4], sync_in[2:1]};
   assign act      = io.en ? (edge_src & ~prev_q) : 6'd0;

   logic [3:0] c_tens_q, c_tens_d, c_units_q, c_units_d, c_tenths_q, c_tenths_d;
   logic [3:0] pre_tens_q, pre_tens_d, pre_units_q, pre_units_d;
   logic       dir_q, dir_d, run_q, run_d, paused_q, paused_d, mode_q, mode_d, led_q, led_d;
   speed_e     speed_q, speed_d;
   logic [CW-1:0] cnt_q, cnt_d, period_m1;
   logic       tick, advance;
   logic [3:0] st_tens, st_units, st_tenths, ld_tens, ld_units;

   always_comb begin
      period_m1 = CW'(CLK_HZ / (10 * SPEED_MULT[0]) - 1);
      case (speed_q)
         SPD_X2:  period_m1 = CW'(CLK_HZ / (10 * SPEED_MULT[1]) - 1);
         SPD_X4:  period_m1 = CW'(CLK_HZ / (10 * SPEED_MULT[2]) - 1);
         SPD_X10: period_m1 = CW'(CLK_HZ / (10 * SPEED_MULT[3]) - 1);
         default: ;
      endcase
   end

   assign tick     = (cnt_q == period_m1);
   assign advance  = tick & run_q & io.en & ~paused_q & ~key2 & ~led_q;
   assign ld_tens  = (io.ten > MAX_TENS)  ? MAX_TENS  : io.ten;
   assign ld_units = (io.one > MAX_DIGIT) ? MAX_DIGIT : io.one;

   // One 0.1 s step with decimal carry/borrow.
   always_comb begin
      st_tens   = c_tens_q;
      st_units  = c_units_q;
      st_tenths = c_tenths_q;
      if (!dir_q) begin
         if (c_tenths_q == MAX_DIGIT) begin
            st_tenths = 4'd0;
            if (c_units_q == MAX_DIGIT) begin
               st_units = 4'd0;
               st_tens  = c_tens_q + 4'd1;
            end else st_units = c_units_q + 4'd1;
         end else st_tenths = c_tenths_q + 4'd1;
      end else begin
         if (c_tenths_q == 4'd0) begin
            st_tenths = MAX_DIGIT;
            if (c_units_q == 4'd0) begin
               st_units = MAX_DIGIT;
               st_tens  = c_tens_q - 4'd1;
            end else st_units = c_units_q - 4'd1;
         end else st_tenths = c_tenths_q - 4'd1;
      end
   end

   always_comb begin
      c_tens_d = c_tens_q; c_units_d = c_units_q; c_tenths_d = c_tenths_q;
      pre_tens_d = pre_tens_q; pre_units_d = pre_units_q;
      dir_d = dir_q; run_d = run_q; paused_d = paused_q;
      speed_d = speed_q; mode_d = mode_q; led_d = led_q;
      prev_d = edge_src;
      cnt_d  = tick ? '0 : cnt_q + 1'b1;
      if (!ret_n) begin
         c_tens_d = pre_tens_q; c_units_d = pre_units_q; c_tenths_d = 4'd0;
         run_d = 1'b0; led_d = 1'b0; cnt_d = '0;
      end else begin
         if (act[1]) begin dir_d = ~dir_q; led_d = 1'b0; end
         if (act[3]) begin speed_d = speed_e'(speed_q + 2'd1); cnt_d = '0; end
         if (act[4]) mode_d = ~mode_q;
         if (act[5]) paused_d = ~paused_q;
         if (act[0]) begin run_d = 1'b1; led_d = 1'b0; end
         // Load beats start, start beats a tick.
         if (act[2] && key2) begin
            c_tens_d = ld_tens; c_units_d = ld_units; c_tenths_d = 4'd0;
            pre_tens_d = ld_tens; pre_units_d = ld_units;
            led_d = 1'b0; cnt_d = '0;
         end else if (act[0]) begin
            c_tens_d = pre_tens_q; c_units_d = pre_units_q; c_tenths_d = 4'd0;
         end else if (advance) begin
            if (at_limit(dir_q, c_tens_q, c_units_q, c_tenths_q)) led_d = 1'b1;
            else begin
               c_tens_d = st_tens; c_units_d = st_units; c_tenths_d = st_tenths;
               led_d = at_limit(dir_q, st_tens, st_units, st_tenths);
            end
         end
      end
   end

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         c_tens_q <= '0; c_units_q <= '0; c_tenths_q <= '0;
         pre_tens_q <= '0; pre_units_q <= '0;
         dir_q <= 1'b0; run_q <= 1'b0; paused_q <= 1'b0;
         speed_q <= SPD_X1; mode_q <= 1'b0; led_q <= 1'b0;
         prev_q <= '0; cnt_q <= '0;
      end else begin
         c_tens_q <= c_tens_d; c_units_q <= c_units_d; c_tenths_q <= c_tenths_d;
         pre_tens_q <= pre_tens_d; pre_units_q <= pre_units_d;
         dir_q <= dir_d; run_q <= run_d; paused_q <= paused_d;
         speed_q <= speed_d; mode_q <= mode_d; led_q <= led_d;
         prev_q <= prev_d; cnt_q <= cnt_d;
      end
   end

   logic [6:0] ge_seg, xiao_seg, ge_q, ge_d, xiao_q, xiao_d;
   logic [3:0] tens_o_q, tens_o_d;
   logic       point_q, point_d, led_o_q, led_o_d;

   seg7_decode u_ge   (.bcd(c_units_q),  .seg(ge_seg));
   seg7_decode u_xiao (.bcd(c_tenths_q), .seg(xiao_seg));

   always_comb begin
      tens_o_d = c_tens_q;
      ge_d     = ge_seg;
      xiao_d   = mode_q ? SEG_BLANK : xiao_seg;
      point_d  = ~mode_q;
      led_o_d  = led_q;
   end

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         tens_o_q <= '0; ge_q <= SEG_0; xiao_q <= SEG_0;
         point_q <= 1'b1; led_o_q <= 1'b0;
      end else begin
         tens_o_q <= tens_o_d; ge_q <= ge_d; xiao_q <= xiao_d;
         point_q <= point_d; led_o_q <= led_o_d;
      end
   end

   assign io.tens     = tens_o_q;
   assign io.out_ge   = ge_q;
   assign io.out_xiao = xiao_q;
   assign io.point    = point_q;
   assign io.led      = led_o_q;
endmodule

// File: tb/tb_timer_60s_core.sv
// Directed bench for timer_60s_core at CLK_HZ = 1000 (100-cycle tick at x1).
module tb_timer_60s_core;
   logic clk_50M = 1'b0;
   logic rst     = 1'b1;
   int   nvec    = 0;
   int   nfail   = 0;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SB = 7'b1111111;

   timer_60s_core_if ifc ();
   timer_60s_core #(.CLK_HZ(1000)) dut (.clk_50M(clk_50M), .rst(rst), .io(ifc));

   always #5 clk_50M = ~clk_50M;

   typedef struct {
      logic [3:0] ten, one, exp_tens;
      logic [6:0] exp_ge;
   } vec_t;
   vec_t vt [12];

   task automatic step(input int n);
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_disp(input string name, input logic [3:0] t, input logic [6:0] g,
                           input logic [6:0] x);
      chk({name, ".tens"}, 32'(ifc.tens), 32'(t));
      chk({name, ".ge"}, 32'(ifc.out_ge), 32'(g));
      chk({name, ".xiao"}, 32'(ifc.out_xiao), 32'(x));
   endtask

   task automatic load(input logic [3:0] t, input logic [3:0] o);
      ifc.key2 = 1'b1; ifc.ten = t; ifc.one = o;
      ifc.key4 = 1'b1; step(1);
      ifc.key4 = 1'b0; step(2);
   endtask

   task automatic sync_ret();
      ifc.ret = 1'b0; step(1);
      ifc.ret = 1'b1;
   endtask

   initial begin
      vt[0]  = '{4'd2,  4'd3,  4'd2, S3};
      vt[1]  = '{4'd3,  4'd4,  4'd3, S4};
      vt[2]  = '{4'd4,  4'd5,  4'd4, S5};
      vt[3]  = '{4'd5,  4'd6,  4'd5, S6};
      vt[4]  = '{4'd1,  4'd7,  4'd1, S7};
      vt[5]  = '{4'd0,  4'd8,  4'd0, S8};
      vt[6]  = '{4'd6,  4'd1,  4'd5, S1};
      vt[7]  = '{4'd9,  4'd2,  4'd5, S2};
      vt[8]  = '{4'd15, 4'd10, 4'd5, S9};
      vt[9]  = '{4'd3,  4'd15, 4'd3, S9};
      vt[10] = '{4'd1,  4'd9,  4'd1, S9};
      vt[11] = '{4'd0,  4'd0,  4'd0, S0};

      ifc.ret = 1'b1; ifc.en = 1'b0; ifc.pause = 1'b0;
      ifc.key0 = 1'b0; ifc.key1 = 1'b0; ifc.key2 = 1'b0;
      ifc.key4 = 1'b0; ifc.key5 = 1'b0; ifc.key6 = 1'b0;
      ifc.ten = 4'd0; ifc.one = 4'd0;

      // Reset values
      step(3);
      chk_disp("rst", 4'd0, S0, S0);
      chk("rst.point", 32'(ifc.point), 32'd1);
      chk("rst.led", 32'(ifc.led), 32'd0);
      rst = 1'b0;
      step(2);

      // en = 0: every key edge ignored
      ifc.key0 = 1'b1; ifc.key1 = 1'b1; ifc.key5 = 1'b1; ifc.key6 = 1'b1; ifc.pause = 1'b1;
      step(1);
      ifc.key0 = 1'b0; ifc.key1 = 1'b0; ifc.key5 = 1'b0; ifc.key6 = 1'b0; ifc.pause = 1'b0;
      step(1);
      load(4'd3, 4'd3);
      ifc.key2 = 1'b0;
      step(300);
      chk_disp("idle", 4'd0, S0, S0);
      chk("idle.point", 32'(ifc.point), 32'd1);
      chk("idle.led", 32'(ifc.led), 32'd0);

      // Load table: clamping and every units segment code
      ifc.en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         load(vt[i].ten, vt[i].one);
         chk_disp($sformatf("load%0d", i), vt[i].exp_tens, vt[i].exp_ge, S0);
      end
      ifc.key2 = 1'b0;

      // Up count from 00.0, tick phase aligned by ret
      sync_ret();
      ifc.key0 = 1'b1; step(1);
      ifc.key0 = 1'b0; step(99);
      chk("up.pre_tick", 32'(ifc.out_xiao), 32'(S0));
      step(1);
      chk("up.first_tick", 32'(ifc.out_xiao), 32'(S1));
      step(549);
      chk_disp("up.0_6", 4'd0, S0, S6);
      step(400);
      chk_disp("up.1_0", 4'd0, S1, S0);

      // Load 59 while running, then run into 59.9
      load(4'd5, 4'd9);
      ifc.key2 = 1'b0;
      step(1200);
      chk_disp("up.end", 4'd5, S9, S9);
      chk("up.end.led", 32'(ifc.led), 32'd1);
      step(300);
      chk_disp("up.hold", 4'd5, S9, S9);
      chk("up.hold.led", 32'(ifc.led), 32'd1);

      // key1 clears led and turns to down
      ifc.key1 = 1'b1; step(1);
      ifc.key1 = 1'b0; step(2);
      chk("dir.led_clr", 32'(ifc.led), 32'd0);

      // Down count from 19.0 to 00.0
      load(4'd1, 4'd9);
      chk_disp("dn.load", 4'd1, S9, S0);
      ifc.key2 = 1'b0; ifc.key0 = 1'b1; step(1);
      ifc.key0 = 1'b0; step(147);
      chk_disp("dn.borrow", 4'd1, S8, S9);
      step(19150);
      chk_disp("dn.end", 4'd0, S0, S0);
      chk("dn.end.led", 32'(ifc.led), 32'd1);
      step(300);
      chk_disp("dn.hold", 4'd0, S0, S0);
      chk("dn.hold.led", 32'(ifc.led), 32'd1);

      // Out-of-range preset clamps to 59
      load(4'd7, 4'd12);
      chk_disp("clamp", 4'd5, S9, S0);
      chk("clamp.led", 32'(ifc.led), 32'd0);
      ifc.key2 = 1'b0;

      // Pause: down from 59.0, frozen at 58.8 across several periods
      sync_ret();
      ifc.key0 = 1'b1; step(1);
      ifc.key0 = 1'b0; step(249);
      ifc.pause = 1'b1; step(1);
      ifc.pause = 1'b0; step(9);
      chk_disp("pause.a", 4'd5, S8, S8);
      step(391);
      chk_disp("pause.b", 4'd5, S8, S8);
      ifc.pause = 1'b1; step(1);
      ifc.pause = 1'b0; step(98);
      chk_disp("resume", 4'd5, S8, S7);

      // Speed: three key5 edges -> x10, fourth -> x1
      sync_ret();
      for (int i = 0; i < 3; i++) begin
         ifc.key5 = 1'b1; step(1);
         ifc.key5 = 1'b0;
         if (i < 2) step(1);
      end
      ifc.key0 = 1'b1; step(1);
      ifc.key0 = 1'b0; step(9);
      chk("x10.pre_tick", 32'(ifc.out_xiao), 32'(S0));
      step(1);
      chk_disp("x10.tick1", 4'd5, S8, S9);
      step(10);
      chk("x10.tick2", 32'(ifc.out_xiao), 32'(S8));
      ifc.key5 = 1'b1; step(1);
      ifc.key5 = 1'b0; step(50);
      chk("x1.mid", 32'(ifc.out_xiao), 32'(S8));
      step(50);
      chk("x1.pre_tick", 32'(ifc.out_xiao), 32'(S8));
      step(1);
      chk("x1.tick", 32'(ifc.out_xiao), 32'(S7));

      // Display mode toggle
      ifc.key6 = 1'b1; step(1);
      ifc.key6 = 1'b0; step(1);
      chk_disp("mode1", 4'd5, S8, SB);
      chk("mode1.point", 32'(ifc.point), 32'd0);
      ifc.key6 = 1'b1; step(1);
      ifc.key6 = 1'b0; step(1);
      chk_disp("mode0", 4'd5, S8, S7);
      chk("mode0.point", 32'(ifc.point), 32'd1);

      // ret low mid-run: back to preset, stopped
      sync_ret();
      step(2);
      chk_disp("ret", 4'd5, S9, S0);
      chk("ret.led", 32'(ifc.led), 32'd0);
      step(300);
      chk_disp("ret.stopped", 4'd5, S9, S0);

      // Async reset mid-run
      ifc.key0 = 1'b1; step(1);
      ifc.key0 = 1'b0; step(150);
      rst = 1'b1; #2;
      chk_disp("arst", 4'd0, S0, S0);
      chk("arst.point", 32'(ifc.point), 32'd1);
      chk("arst.led", 32'(ifc.led), 32'd0);
      step(2);
      rst = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/timer_60s_core.md
Name: timer_60s_core

Overview:
Stopwatch/countdown timer with a 0.0–59.9 s range and 0.1 s resolution, driven from a 50 MHz board clock. Supports the following:
- up or down counting
- preset load from switches
- pause
- four speed multipliers
- two display modes

Drives two seven-segment digits (units, tenths), a BCD tens value, a decimal point and a terminal-count LED. Sits between board keys/switches and the display driver.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; must be divisible by 100 (bench uses 1000).

Ports:
clk_50M  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
ret  in  1  synchronous restart, active-low: count := preset, run := 0, led := 0.
en  in  1  global enable; 0 freezes count and ignores key edges.
key0  in  1  start; rising edge sets run.
key1  in  1  rising edge toggles direction (0 = up, 1 = down).
key2  in  1  set mode (level); while 1, counting is suspended.
key4  in  1  load strobe; rising edge while key2 = 1 loads {ten,one} into preset and count.
key5  in  1  rising edge cycles speed x1 -> x2 -> x4 -> x10 -> x1.
key6  in  1  rising edge toggles display mode.
ten  in  4  preset tens digit; values >5 clamp to 5.
one  in  4  preset units digit; values >9 clamp to 9.
pause  in  1  rising edge toggles paused.
tens  out  4  BCD tens of seconds, 0..5.
out_ge  out  7  segments for units digit, {g,f,e,d,c,b,a}, active-low.
out_xiao  out  7  segments for tenths digit, same encoding.
point  out  1  decimal point, active-high.
led  out  1  terminal-count indicator.

Behaviour:
- State:
  - count: tens 0..5, units 0..9, tenths 0..9.
  - preset: 00.
  - dir, run, paused, speed index 0..3, mode, led.
- Reset (rst = 1, async): every state bit clears.
  - count = 00.0, preset = 00, dir = up, speed = x1, mode = 0, run = paused = led = 0.
  - Outputs: tens = 0, out_ge = out_xiao = 7'b1000000, point = 1, led = 0.
- Edge detect:
  - One register per key/pause; an edge acts on the cycle after the input rises.
  - Edges are acted on only when en = 1.
- Tick generator: counter period P = CLK_HZ/(10*mult), mult in {1,2,4,10}.
  - Emits a one-cycle tick at the end of each period.
  - Counter restarts from 0 on a speed change, ret, or load.
- Advance: count steps by 0.1 s on a tick only when run & en & !paused & !key2 & !led.
  - Up: tenths 9 -> 0 carries to units; units 9 -> 0 carries to tens.
  - Up: on reaching 59.9, count holds and led = 1.
  - Down: borrows symmetrically; on reaching 00.0, count holds and led = 1.
- led = 1 freezes counting. It clears on any of:
  - ret low
  - load
  - key1 edge
  - key0 edge (key0 also restarts from preset)
- Load: count := {clamped ten, clamped one}.0 and preset := same. run is unchanged.
- ret low has priority over all key edges in the same cycle. Load has priority over a tick.
- Simultaneous key1 and key2 edges are both applied.
- Display:
  - mode 0: out_ge = units, out_xiao = tenths, point = 1.
  - mode 1: out_ge = units, out_xiao = blank (7'b1111111), point = 0.
  - tens is always the BCD tens value.
  - Outputs are registered: one cycle after the state change.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

Optional Feature:
KEY_SYNC_EN:
- Defined: key0..key6, pause and ret pass through 2-flop synchronizers before edge detection, adding 2 cycles of latency.
- Undefined: inputs feed edge detection directly.

Decomposition:
Package timer_60s_pkg holds:
- speed index type and the multiplier table {1,2,4,10}
- segment constants SEG_0..SEG_9 and SEG_BLANK
- MAX_TENS = 5
One natural sub-module: seg7_decode (4-bit BCD in, 7-bit active-low segments out; codes >9 give blank), instantiated twice.

Test Plan:
- Reset and idle: rst = 1 -> tens = 0, out_ge = out_xiao = 1000000, point = 1, led = 0. With en = 0 and key pulses, nothing changes.
- Up count: CLK_HZ = 1000, en = 1, key0 pulse -> after 100 cycles tenths = 1; after 600 cycles units = 0, tenths = 6. Run to 59.9 -> holds, led = 1.
- Load and down count:
  - key1 pulse, key2 = 1, ten = 1, one = 9, key4 pulse -> tens = 1, out_ge = 0010000.
  - key2 = 0, key0 pulse -> count reaches 00.0 and holds, led = 1.
  - ten = 7, one = 12 on load -> 59.
- Pause: pause pulse mid-run -> count frozen for 400 cycles; second pulse -> resumes.
- Speed and display:
  - 3 key5 pulses -> x10, tick every 10 cycles; a fourth pulse -> back to x1.
  - key6 pulse -> out_xiao = 1111111, point = 0; second pulse -> restored.
- Restart: ret low for 1 cycle mid-run -> count = preset, run = 0, led = 0. rst asserted mid-run -> immediate reset values.
